// File: rtl/sync_count_checker.sv
// sync_count_checker: verifies a free-running binary counter increments by one per valid sample.
// Optional macro SYNC_COUNT_CHECKER_FAULT_LATCH_EN makes a locked mismatch latch into FAULT until reset.
`default_nettype none

module sync_count_checker #(
  parameter int WIDTH     = 3,
  parameter int LOCK_CNT  = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     count,
  input  logic                 valid,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 wrap_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [GOOD_W-1:0] LOCK_GOOD = GOOD_W'(LOCK_CNT);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

`ifdef SYNC_COUNT_CHECKER_FAULT_LATCH_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, LOCK = 2'd2, FAULT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, LOCK = 2'd2} state_t;
`endif

  state_t                 state, state_n;
  logic [WIDTH-1:0]       prev, prev_n;
  logic [GOOD_W-1:0]      good, good_n;
  logic [ERR_CNT_W-1:0]   err_cnt_n;
  logic [WIDTH-1:0]       expected_n;
  logic                   err_pulse_n, wrap_pulse_n;

  logic [WIDTH-1:0]       prev_inc, count_inc;
  logic [GOOD_W-1:0]      good_inc;
  logic                   match;

  assign prev_inc  = prev + WIDTH'(1);
  assign count_inc = count + WIDTH'(1);
  assign good_inc  = good + GOOD_W'(1);
  assign match     = (count == prev_inc);

  always_comb begin
    state_n      = state;
    prev_n       = prev;
    good_n       = good;
    err_cnt_n    = err_count;
    expected_n   = expected;
    err_pulse_n  = 1'b0;
    wrap_pulse_n = 1'b0;
    if (valid) begin
      case (state)
        IDLE: begin
          prev_n     = count;
          good_n     = '0;
          expected_n = count_inc;
          state_n    = ACQ;
        end
        ACQ: begin
          prev_n     = count;
          expected_n = count_inc;
          if (match) begin
            good_n = good_inc;
            if (good_inc == LOCK_GOOD) state_n = LOCK;
          end else begin
            good_n = '0;
          end
        end
        LOCK: begin
          prev_n     = count;
          expected_n = count_inc;
          if (match) begin
            wrap_pulse_n = (&prev) && (count == '0);
          end else begin
            err_pulse_n = 1'b1;
            err_cnt_n   = (err_count == ERR_MAX) ? err_count : err_count + ERR_CNT_W'(1);
            good_n      = '0;
`ifdef SYNC_COUNT_CHECKER_FAULT_LATCH_EN
            state_n     = FAULT;
`else
            state_n     = ACQ;
`endif
          end
        end
        // FAULT (when present) absorbs every sample until reset.
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= '0;
      good       <= '0;
      err_count  <= '0;
      expected   <= '0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      good       <= good_n;
      err_count  <= err_cnt_n;
      expected   <= expected_n;
      err_pulse  <= err_pulse_n;
      wrap_pulse <= wrap_pulse_n;
      locked     <= (state_n == LOCK);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_count_checker.sv
// tb_sync_count_checker: directed plus randomized stimulus against a behavioural counter-checker model.
`default_nettype none

module tb_sync_count_checker;

  localparam int WIDTH     = 3;
  localparam int LOCK_CNT  = 2;
  localparam int ERR_CNT_W = 2;
  localparam int MODN      = 1 << WIDTH;
  localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [WIDTH-1:0]     count = '0;
  logic                 valid = 1'b0;
  logic                 locked, err_pulse, wrap_pulse;
  logic [ERR_CNT_W-1:0] err_count;
  logic [WIDTH-1:0]     expected;

  sync_count_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .reset(reset), .count(count), .valid(valid),
    .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
    .err_count(err_count), .expected(expected)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: "seen" = any sample since reset, "streak" = consecutive correct steps.
  bit seen, is_locked, faulted;
  int m_prev, streak, m_errs, m_exp;
  bit m_err, m_wrap;
  int ctr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input int c);
    m_err = 0; m_wrap = 0;
    if (r) begin
      seen = 0; is_locked = 0; faulted = 0;
      m_prev = 0; streak = 0; m_errs = 0; m_exp = 0;
    end else if (v && !faulted) begin
      if (!seen) begin
        seen = 1; streak = 0;
      end else if (c == (m_prev + 1) % MODN) begin
        if (is_locked) m_wrap = (m_prev == MODN - 1);
        else begin
          streak++;
          if (streak >= LOCK_CNT) is_locked = 1;
        end
      end else begin
        streak = 0;
        if (is_locked) begin
          m_err = 1;
          if (m_errs < ERR_MAX) m_errs++;
          is_locked = 0;
`ifdef SYNC_COUNT_CHECKER_FAULT_LATCH_EN
          faulted = 1;
`endif
        end
      end
      m_prev = c;
      m_exp  = (c + 1) % MODN;
    end
  endtask

  task automatic step(input bit r, input bit v, input int c);
    reset = r; valid = v; count = WIDTH'(c);
    @(posedge clk);
    model(r, v, c);
    #1;
    check("locked", {31'd0, locked}, {31'd0, is_locked});
    check("err_pulse", {31'd0, err_pulse}, {31'd0, m_err});
    check("wrap_pulse", {31'd0, wrap_pulse}, {31'd0, m_wrap});
    check("err_count", 32'(err_count), 32'(m_errs));
    check("expected", 32'(expected), 32'(m_exp));
    if (v) ctr = (c + 1) % MODN;
  endtask

  task automatic run_count(input int n);
    for (int i = 0; i < n; i++) step(0, 1, ctr);
  endtask

  initial begin
    ctr = 0;
    model(1, 0, 0);
    #1;
    step(1, 0, 0);
    check("reset_locked", {31'd0, locked}, 32'd0);
    check("reset_expected", 32'(expected), 32'd0);

    // Lock acquisition and two full wraps.
    ctr = 0;
    run_count(3);
    check("lock_after_2", {31'd0, locked}, 32'd1);
    check("expected_3", 32'(expected), 32'd3);
    run_count(16);

    // Skip 3 -> 5, then 6, 7.
    step(0, 1, 3);
    step(0, 1, 5);
    check("skip_err_pulse", {31'd0, err_pulse}, 32'd1);
    check("skip_err_count", 32'(err_count), 32'd1);
    run_count(2);

    // Hold with valid low while count keeps moving.
    step(1, 0, 0);
    ctr = 0;
    run_count(5);
    for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(0, MODN - 1));
    step(0, 1, 5);

    // Saturation: five mismatches, relocking between each.
    for (int k = 0; k < 5; k++) begin
      step(0, 1, (ctr + 3) % MODN);
      run_count(LOCK_CNT + 1);
    end
    check("sat_count", 32'(err_count), 32'(ERR_MAX));

    // Reset mid-operation.
    step(1, 0, 0);
    check("midreset_err", 32'(err_count), 32'd0);
    ctr = 2;
    run_count(LOCK_CNT + 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      int r, c;
      bit v;
      r = $urandom_range(0, 99);
      v = (r >= 15);
      c = ($urandom_range(0, 15) == 0) ? $urandom_range(0, MODN - 1) : ctr;
      step(r < 2, v, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
